// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the multi-cycle ALU (alu_mdu):
//   - ALUOP_* 5-bit operation codes
//   - FSM state type (IDLE / CALC / FIN)
//   - helper predicates used to classify operations
// Codes 27..31 are unassigned and execute as undefined ops (result 0).
package alu_pkg;

    localparam logic [4:0] ALUOP_ADD    = 5'd0;
    localparam logic [4:0] ALUOP_SUB    = 5'd1;
    localparam logic [4:0] ALUOP_AND    = 5'd2;
    localparam logic [4:0] ALUOP_OR     = 5'd3;
    localparam logic [4:0] ALUOP_XOR    = 5'd4;
    localparam logic [4:0] ALUOP_SLL    = 5'd5;
    localparam logic [4:0] ALUOP_SRL    = 5'd6;
    localparam logic [4:0] ALUOP_SRA    = 5'd7;
    localparam logic [4:0] ALUOP_SLT    = 5'd8;
    localparam logic [4:0] ALUOP_SLTU   = 5'd9;
    localparam logic [4:0] ALUOP_LUI    = 5'd10;
    localparam logic [4:0] ALUOP_AUIPC  = 5'd11;
    localparam logic [4:0] ALUOP_JALR   = 5'd12;
    localparam logic [4:0] ALUOP_BEQ    = 5'd13;
    localparam logic [4:0] ALUOP_BNE    = 5'd14;
    localparam logic [4:0] ALUOP_BLT    = 5'd15;
    localparam logic [4:0] ALUOP_BGE    = 5'd16;
    localparam logic [4:0] ALUOP_BLTU   = 5'd17;
    localparam logic [4:0] ALUOP_BGEU   = 5'd18;
    localparam logic [4:0] ALUOP_MUL    = 5'd19;
    localparam logic [4:0] ALUOP_MULH   = 5'd20;
    localparam logic [4:0] ALUOP_MULHSU = 5'd21;
    localparam logic [4:0] ALUOP_MULHU  = 5'd22;
    localparam logic [4:0] ALUOP_DIV    = 5'd23;
    localparam logic [4:0] ALUOP_DIVU   = 5'd24;
    localparam logic [4:0] ALUOP_REM    = 5'd25;
    localparam logic [4:0] ALUOP_REMU   = 5'd26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    // M-extension op (multiply or divide family)
    function automatic logic is_muldiv(input logic [4:0] op);
        return (op >= ALUOP_MUL) && (op <= ALUOP_REMU);
    endfunction

    // Divide/remainder family only
    function automatic logic is_div(input logic [4:0] op);
        return (op >= ALUOP_DIV) && (op <= ALUOP_REMU);
    endfunction

    function automatic logic is_branch(input logic [4:0] op);
        return (op >= ALUOP_BEQ) && (op <= ALUOP_BGEU);
    endfunction

    // Both operands are interpreted as two's complement. MULHSU is
    // signed only in operand A and is handled separately by the caller.
    function automatic logic is_signed_op(input logic [4:0] op);
        return (op == ALUOP_SLT) || (op == ALUOP_BLT) || (op == ALUOP_BGE) ||
               (op == ALUOP_MUL) || (op == ALUOP_MULH) ||
               (op == ALUOP_DIV) || (op == ALUOP_REM);
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// alu_mdu_iter
// Iterative step datapath shared by multiply and divide. One step per
// cycle while en is high; a step is a shift-add (multiply) or a
// restoring shift-subtract (divide) through one adder/subtractor.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset (counter only)
//   load             capture operand magnitudes, clear accumulator/counter
//   en               perform one iteration
//   div_mode         at load: 1 = divide, 0 = multiply
//   mag_a, mag_b     unsigned operand magnitudes
//   acc_hi, acc_lo   accumulator halves: product {hi,lo} or {rem,quot}
//   last             current iteration is the final one (XLEN-1)
module alu_mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load,
    input  logic            en,
    input  logic            div_mode,
    input  logic [XLEN-1:0] mag_a,
    input  logic [XLEN-1:0] mag_b,
    output logic [XLEN-1:0] acc_hi,
    output logic [XLEN-1:0] acc_lo,
    output logic            last
);

    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] hi_q, lo_q, opnd_q;
    logic            div_q;
    logic [XLEN:0]   x, y;
    logic [XLEN+1:0] sum;
    logic [XLEN-1:0] hi_n, lo_n;

    // Multiply: lo holds the multiplier and shifts out LSB-first while
    // the partial product enters from the top. Divide: lo holds the
    // dividend shifting out MSB-first and fills with quotient bits.
    always_comb begin
        x    = div_q ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
        y    = {1'b0, opnd_q};
        sum  = div_q ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        hi_n = hi_q;
        lo_n = lo_q;
        if (div_q) begin
            // top bit of sum set means borrow: restore the shifted value
            if (!sum[XLEN+1]) begin
                hi_n = sum[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_n = x[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b0};
            end
        end else if (lo_q[0]) begin
            {hi_n, lo_n} = {sum[XLEN:0], lo_q[XLEN-1:1]};
        end else begin
            {hi_n, lo_n} = {1'b0, hi_q, lo_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            div_q  <= div_mode;
            hi_q   <= '0;
            lo_q   <= div_mode ? mag_a : mag_b;
            opnd_q <= div_mode ? mag_b : mag_a;
        end else if (en) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
        end
    end

    assign acc_hi = hi_q;
    assign acc_lo = lo_q;
    assign last   = (cnt_q == CW'(XLEN - 1));

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu
// Multi-cycle ALU for the execute state. Single-cycle RV32I/RV64I ops
// complete with done one cycle after acceptance; M-extension ops iterate
// for XLEN cycles in alu_mdu_iter and then apply sign correction.
// Build option: define ALU_MULDIV_EN to include the M-extension. Without
// it, M ops act as undefined ops and busy is tied low.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   start       request, accepted only while busy is low
//   kill        abort of an in-flight operation (no done, result kept)
//   op          ALUOP_* operation code
//   a, b        operands, sampled only at acceptance
//   busy        multi-cycle op in flight
//   done        one-cycle pulse when result is updated
//   result      registered result, held until the next completion
//   taken       branch condition (branch ops only)
module alu_mdu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            kill,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            taken
);

    localparam int SHW = $clog2(XLEN);

    logic signed [XLEN-1:0] a_s, b_s;
    logic [SHW-1:0]  shamt;
    logic            lt_s, lt_u, eq;
    logic [XLEN-1:0] sc_result;
    logic            sc_taken;

    logic            done_q, taken_q;
    logic [XLEN-1:0] result_q;
    logic            res_we, done_d, taken_d;
    logic [XLEN-1:0] res_d;

`ifdef ALU_MULDIV_EN
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q, state_d;
    logic            sa, sb, div_zero, div_ovf, special, go_iter;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            iter_load, iter_en, iter_last;
    logic [XLEN-1:0] acc_hi, acc_lo;
    logic [4:0]      op_q;
    logic            neg_q, negr_q;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] quot, rem, fin_result;
`endif

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[SHW-1:0];
    assign lt_s  = a_s < b_s;
    assign lt_u  = a < b;
    assign eq    = a == b;

`ifdef ALU_MULDIV_EN
    // Operand classification and the one-cycle divide special cases
    always_comb begin
        sa       = is_signed_op(op) || (op == ALUOP_MULHSU);
        sb       = is_signed_op(op);
        mag_a    = (sa && a[XLEN-1]) ? -a : a;
        mag_b    = (sb && b[XLEN-1]) ? -b : b;
        div_zero = (b == '0);
        div_ovf  = is_signed_op(op) && (a == XMIN) && (b == '1);
        special  = is_div(op) && (div_zero || div_ovf);
        go_iter  = is_muldiv(op) && !special;
    end
`endif

    // Single-cycle ALU, including the divide special cases
    always_comb begin
        sc_result = '0;
        case (op)
            ALUOP_ADD, ALUOP_AUIPC, ALUOP_JALR: sc_result = a + b;
            ALUOP_SUB:  sc_result = a - b;
            ALUOP_AND:  sc_result = a & b;
            ALUOP_OR:   sc_result = a | b;
            ALUOP_XOR:  sc_result = a ^ b;
            ALUOP_LUI:  sc_result = b;
            ALUOP_SLL:  sc_result = a << shamt;
            ALUOP_SRL:  sc_result = a >> shamt;
            ALUOP_SRA:  sc_result = a_s >>> shamt;
            ALUOP_SLT, ALUOP_BLT:   sc_result = XLEN'(lt_s);
            ALUOP_SLTU, ALUOP_BLTU: sc_result = XLEN'(lt_u);
            ALUOP_BEQ:  sc_result = XLEN'(eq);
            ALUOP_BNE:  sc_result = XLEN'(!eq);
            ALUOP_BGE:  sc_result = XLEN'(!lt_s);
            ALUOP_BGEU: sc_result = XLEN'(!lt_u);
`ifdef ALU_MULDIV_EN
            ALUOP_DIV, ALUOP_DIVU: sc_result = div_zero ? '1 : XMIN;
            ALUOP_REM, ALUOP_REMU: sc_result = div_zero ? a : '0;
`endif
            default:    sc_result = '0;
        endcase
        sc_taken = is_branch(op) && sc_result[0];
    end

`ifdef ALU_MULDIV_EN
    alu_mdu_iter #(.XLEN(XLEN)) u_iter (
        .clk      (clk),
        .rstn     (rstn),
        .load     (iter_load),
        .en       (iter_en),
        .div_mode (is_div(op)),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .acc_hi   (acc_hi),
        .acc_lo   (acc_lo),
        .last     (iter_last)
    );

    // Sign correction of the unsigned iteration result
    always_comb begin
        prod   = {acc_hi, acc_lo};
        prod_s = neg_q ? -prod : prod;
        quot   = neg_q ? -acc_lo : acc_lo;
        rem    = negr_q ? -acc_hi : acc_hi;
        case (op_q)
            ALUOP_MUL:                            fin_result = prod_s[XLEN-1:0];
            ALUOP_MULH, ALUOP_MULHSU, ALUOP_MULHU: fin_result = prod_s[2*XLEN-1:XLEN];
            ALUOP_DIV, ALUOP_DIVU:                fin_result = quot;
            default:                              fin_result = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (iter_load) begin
            op_q   <= op;
            neg_q  <= (sa && a[XLEN-1]) ^ (sb && b[XLEN-1]);
            negr_q <= sa && a[XLEN-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end
`endif

    // Next state and result-register control
    always_comb begin
        res_we  = 1'b0;
        done_d  = 1'b0;
        res_d   = sc_result;
        taken_d = sc_taken;
`ifdef ALU_MULDIV_EN
        state_d   = state_q;
        iter_load = 1'b0;
        iter_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (go_iter) begin
                        iter_load = 1'b1;
                        state_d   = CALC;
                    end else begin
                        res_we = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            CALC: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    iter_en = 1'b1;
                    if (iter_last) state_d = FIN;
                end
            end
            FIN: begin
                if (!kill) begin
                    res_we  = 1'b1;
                    done_d  = 1'b1;
                    res_d   = fin_result;
                    taken_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`else
        if (start) begin
            res_we = 1'b1;
            done_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_q   <= 1'b0;
            result_q <= '0;
            taken_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            if (res_we) begin
                result_q <= res_d;
                taken_q  <= taken_d;
            end
        end
    end

`ifdef ALU_MULDIV_EN
    assign busy = (state_q != IDLE);
`else
    assign busy = 1'b0;
`endif
    assign done   = done_q;
    assign result = result_q;
    assign taken  = taken_q;

endmodule
